// File: rtl/seq_nibble_adder.sv
// Purpose: WIDTH-bit adder built from one 4-bit carry-look-ahead slice, LS nibble first.
// Latency: WIDTH/4 cycles from the accept edge to done_valid; one idle cycle between operations.
// Backpressure: holds DONE with stable outputs while done_ready is low; start_ready only in IDLE.
module seq_nibble_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [1:0]          r_state;
  logic [N-1:0][3:0]   r_a;
  logic [N-1:0][3:0]   r_b;
  logic [N-1:0][3:0]   r_sum;
  logic                r_carry;
  logic [IW-1:0]       r_idx;
  logic                r_c_out;
  logic                r_overflow;

  logic [3:0]          w_an;
  logic [3:0]          w_bn;
  logic [3:0]          w_g;
  logic [3:0]          w_p;
  logic                w_c0;
  logic                w_c1;
  logic                w_c2;
  logic                w_c3;
  logic                w_c4;
  logic [3:0]          w_snib;
  logic                w_last;

  // Current nibble of each latched operand and its generate/propagate terms.
  assign w_an = r_a[r_idx];
  assign w_bn = r_b[r_idx];
  assign w_g  = w_an & w_bn;
  assign w_p  = w_an ^ w_bn;
  assign w_c0 = r_carry;

  // Fully expanded look-ahead carries; c3 of the top nibble is the carry into the MSB.
  assign w_c1 = w_g[0] | (w_p[0] & w_c0);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & w_c0);
  assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c0);

  assign w_snib = w_p ^ {w_c3, w_c2, w_c1, w_c0};
  assign w_last = (r_idx == LAST_IDX);

  // Handshake outputs decode registered state only.
  assign start_ready = (r_state == S_IDLE);
  assign done_valid  = (r_state == S_DONE);
  assign sum         = r_sum;
  assign c_out       = r_c_out;
  assign overflow    = r_overflow;

  // Control FSM and nibble datapath; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_sum   <= '0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= w_snib;
          r_carry      <= w_c4;
          if (w_last) begin
            r_c_out    <= w_c4;
            r_overflow <= w_c3 ^ w_c4;
            r_state    <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (done_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
